// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: pipeline MEM stage has default priority, the
// external port gets a starvation-bounded forced grant and optional locked bursts.
//   state | meaning
//   PRI   | pipeline priority; external wins when pipeline idle or starved
//   BURST | external owns memory until lock/req drops or MAX_BURST grants
module dmem_arbiter #(
  parameter int WIDTH        = 32,
  parameter int INDEX        = 5,
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_BURST    = 8
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             p_req_in,
  input  logic             p_we_in,
  input  logic [WIDTH-1:0] p_addr_in,
  input  logic [WIDTH-1:0] p_data_in,
  output logic             p_stall_out,
  output logic [WIDTH-1:0] p_data_out,
  input  logic             x_req_in,
  input  logic             x_we_in,
  input  logic [WIDTH-1:0] x_addr_in,
  input  logic [WIDTH-1:0] x_data_in,
  input  logic             x_lock_in,
  output logic             x_gnt_out,
  output logic             x_rvalid_out,
  output logic [WIDTH-1:0] x_data_out,
  output logic             mem_we_out,
  output logic             mem_re_out,
  output logic [INDEX-1:0] mem_addr_out,
  output logic [WIDTH-1:0] mem_data_out,
  input  logic [WIDTH-1:0] mem_data_in
);

  typedef enum logic {PRI, BURST} state_e;

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [BW-1:0] BURST_MAX  = BW'(MAX_BURST);

  state_e           state_q, state_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic [BW-1:0]    burst_q, burst_d;
  logic             rvalid_q, rvalid_d;
  logic [WIDTH-1:0] xdata_q, xdata_d;
  logic             x_gnt, p_gnt;

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    burst_d  = burst_q;
    x_gnt    = 1'b0;
    p_gnt    = 1'b0;
    case (state_q)
      PRI: begin
        if (x_req_in && (!p_req_in || starve_q == STARVE_MAX)) begin
          x_gnt = 1'b1;
          // With MAX_BURST of 1 the first grant already exhausts the burst
          if (x_lock_in && MAX_BURST > 1) begin
            state_d = BURST;
            burst_d = BW'(1);
          end
        end else if (p_req_in) begin
          p_gnt = 1'b1;
        end
      end
      BURST: begin
        x_gnt = x_req_in;
        if (x_req_in) burst_d = burst_q + BW'(1);
        if (!x_lock_in || !x_req_in || (burst_q + BW'(1)) == BURST_MAX) begin
          state_d = PRI;
          burst_d = '0;
        end
      end
      default: state_d = PRI;
    endcase

    if (!x_req_in || x_gnt)         starve_d = '0;
    else if (starve_q != STARVE_MAX) starve_d = starve_q + SW'(1);

    if (!rst_n_in) begin
      x_gnt = 1'b0;
      p_gnt = 1'b0;
    end

    rvalid_d = x_gnt && !x_we_in;
    xdata_d  = rvalid_d ? mem_data_in : xdata_q;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q  <= PRI;
      starve_q <= '0;
      burst_q  <= '0;
      rvalid_q <= 1'b0;
      xdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      burst_q  <= burst_d;
      rvalid_q <= rvalid_d;
      xdata_q  <= xdata_d;
    end
  end

  // Ungranted cycles still present the pipeline address so p_data_out tracks it
  assign mem_we_out   = x_gnt ? x_we_in : (p_gnt && p_we_in);
  assign mem_re_out   = x_gnt ? !x_we_in : (p_gnt && !p_we_in);
  assign mem_addr_out = x_gnt ? x_addr_in[INDEX+1:2] : p_addr_in[INDEX+1:2];
  assign mem_data_out = x_gnt ? x_data_in : p_data_in;

  assign p_stall_out  = rst_n_in && p_req_in && !p_gnt;
  assign p_data_out   = mem_data_in;
  assign x_gnt_out    = x_gnt;
  assign x_rvalid_out = rvalid_q;
  assign x_data_out   = xdata_q;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{p_addr_in[WIDTH-1:INDEX+2], p_addr_in[1:0],
                              x_addr_in[WIDTH-1:INDEX+2], x_addr_in[1:0]};

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: per-cycle expectations and external read data
// are queued by the driver and checked by an independent negedge monitor.
module tb_dmem_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        p_req_in, p_we_in;
  logic [31:0] p_addr_in, p_data_in;
  logic        p_stall_out;
  logic [31:0] p_data_out;
  logic        x_req_in, x_we_in, x_lock_in;
  logic [31:0] x_addr_in, x_data_in;
  logic        x_gnt_out, x_rvalid_out;
  logic [31:0] x_data_out;
  logic        mem_we_out, mem_re_out;
  logic [4:0]  mem_addr_out;
  logic [31:0] mem_data_out, mem_data_in;

  always #5 clk_in = ~clk_in;

  dmem_arbiter #(.WIDTH(32), .INDEX(5), .STARVE_LIMIT(4), .MAX_BURST(8)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .p_req_in(p_req_in), .p_we_in(p_we_in), .p_addr_in(p_addr_in), .p_data_in(p_data_in),
    .p_stall_out(p_stall_out), .p_data_out(p_data_out),
    .x_req_in(x_req_in), .x_we_in(x_we_in), .x_addr_in(x_addr_in), .x_data_in(x_data_in),
    .x_lock_in(x_lock_in), .x_gnt_out(x_gnt_out), .x_rvalid_out(x_rvalid_out),
    .x_data_out(x_data_out), .mem_we_out(mem_we_out), .mem_re_out(mem_re_out),
    .mem_addr_out(mem_addr_out), .mem_data_out(mem_data_out), .mem_data_in(mem_data_in)
  );

  // Behavioural dmem: combinational read, write at the grant-cycle edge
  logic [31:0] mem [32];
  assign mem_data_in = mem[mem_addr_out];
  always @(posedge clk_in) if (mem_we_out) mem[mem_addr_out] <= mem_data_out;

  typedef struct {
    logic       pst, gnt, we, re;
    logic       caddr;
    logic [4:0] addr;
    logic       rv;
    logic       cpd;
    logic [31:0] pd;
  } exp_t;

  exp_t        cq[$];
  logic [31:0] rq[$];
  int          checks = 0;
  int          failures = 0;
  bit          armed = 1'b0;

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", n, act, req, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (armed) begin
        if (cq.size() > 0) begin
          e = cq.pop_front();
          check("p_stall", {31'd0, p_stall_out}, {31'd0, e.pst});
          check("x_gnt", {31'd0, x_gnt_out}, {31'd0, e.gnt});
          check("mem_we", {31'd0, mem_we_out}, {31'd0, e.we});
          check("mem_re", {31'd0, mem_re_out}, {31'd0, e.re});
          check("x_rvalid", {31'd0, x_rvalid_out}, {31'd0, e.rv});
          if (e.caddr) check("mem_addr", {27'd0, mem_addr_out}, {27'd0, e.addr});
          if (e.cpd) check("p_data", p_data_out, e.pd);
        end
        if (x_rvalid_out === 1'b1) begin
          if (rq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL x_rdata actual=unexpected_rvalid required=no_rvalid t=%0t", $time);
          end else begin
            check("x_data", x_data_out, rq.pop_front());
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drv(input logic rst, input logic preq, input logic pwe,
                     input logic [31:0] paddr, input logic [31:0] pdata,
                     input logic xreq, input logic xwe, input logic [31:0] xaddr,
                     input logic [31:0] xdata, input logic xlock);
    rst_n_in = rst;
    p_req_in = preq; p_we_in = pwe; p_addr_in = paddr; p_data_in = pdata;
    x_req_in = xreq; x_we_in = xwe; x_addr_in = xaddr; x_data_in = xdata;
    x_lock_in = xlock;
  endtask

  task automatic ex(input logic pst, input logic gnt, input logic we, input logic re,
                    input logic caddr, input logic [4:0] addr, input logic rv,
                    input logic cpd, input logic [31:0] pd);
    exp_t e;
    e.pst = pst; e.gnt = gnt; e.we = we; e.re = re;
    e.caddr = caddr; e.addr = addr; e.rv = rv; e.cpd = cpd; e.pd = pd;
    cq.push_back(e);
  endtask

  task automatic idle();
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset held with requests present: everything gated
    cyc(); drv(0, 1, 0, 32'h10, 0, 1, 0, 32'h0C, 0, 1); ex(0,0,0,0,0,0,0,0,0);
    armed = 1'b1;

    // Pipeline store then load
    cyc(); drv(1, 1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0); ex(0,0,1,0,1,4,0,0,0);
    cyc(); drv(1, 1, 0, 32'h10, 0, 0, 0, 0, 0, 0); ex(0,0,0,1,1,4,0,1,32'hDEADBEEF);

    // External write, read, then back-to-back reads (one with junk addr bits)
    cyc(); drv(1, 0, 0, 0, 0, 1, 1, 32'h0C, 32'h12345678, 0); ex(0,1,1,0,1,3,0,0,0);
    cyc(); drv(1, 0, 0, 0, 0, 1, 0, 32'h0C, 0, 0); ex(0,1,0,1,1,3,0,0,0); rq.push_back(32'h12345678);
    cyc(); drv(1, 1, 0, 32'h0C, 0, 0, 0, 0, 0, 0); ex(0,0,0,1,1,3,1,1,32'h12345678);
    cyc(); drv(1, 0, 0, 0, 0, 1, 0, 32'h10, 0, 0); ex(0,1,0,1,1,4,0,0,0); rq.push_back(32'hDEADBEEF);
    cyc(); drv(1, 0, 0, 0, 0, 1, 0, 32'hFFFFFF8E, 0, 0); ex(0,1,0,1,1,3,1,0,0); rq.push_back(32'h12345678);
    cyc(); idle(); ex(0,0,0,0,0,0,1,0,0);
    cyc(); idle(); ex(0,0,0,0,0,0,0,0,0);

    // Starvation: pipeline wins 4 cycles, external forced on the 5th
    for (int i = 0; i < 4; i++) begin
      cyc(); drv(1, 1, 0, 32'h10, 0, 1, 0, 32'h0C, 0, 0); ex(0,0,0,1,1,4,0,1,32'hDEADBEEF);
    end
    cyc(); drv(1, 1, 0, 32'h10, 0, 1, 0, 32'h0C, 0, 0); ex(1,1,0,1,1,3,0,0,0); rq.push_back(32'h12345678);
    cyc(); drv(1, 1, 0, 32'h10, 0, 0, 0, 0, 0, 0); ex(0,0,0,1,1,4,1,1,32'hDEADBEEF);

    // Locked burst under continuous pipeline traffic: 4 starve, 8 burst, pipeline
    for (int i = 0; i < 4; i++) begin
      cyc(); drv(1, 1, 0, 32'h10, 0, 1, 1, 32'h14, 32'hA5A50000, 1); ex(0,0,0,1,1,4,0,1,32'hDEADBEEF);
    end
    for (int i = 0; i < 8; i++) begin
      cyc(); drv(1, 1, 0, 32'h10, 0, 1, 1, 32'h14, 32'hA5A50000, 1); ex(1,1,1,0,1,5,0,0,0);
    end
    cyc(); drv(1, 1, 0, 32'h14, 0, 1, 1, 32'h14, 32'hA5A50000, 1); ex(0,0,0,1,1,5,0,1,32'hA5A50000);
    cyc(); idle(); ex(0,0,0,0,0,0,0,0,0);

    // Early release: lock dropped on the 3rd grant
    cyc(); drv(1, 0, 0, 0, 0, 1, 1, 32'h18, 32'd1, 1); ex(0,1,1,0,1,6,0,0,0);
    cyc(); drv(1, 1, 0, 32'h18, 0, 1, 1, 32'h18, 32'd2, 1); ex(1,1,1,0,1,6,0,0,0);
    cyc(); drv(1, 1, 0, 32'h18, 0, 1, 1, 32'h18, 32'd3, 0); ex(1,1,1,0,1,6,0,0,0);
    cyc(); drv(1, 1, 0, 32'h18, 0, 0, 0, 0, 0, 0); ex(0,0,0,1,1,6,0,1,32'd3);

    // Reset during the 3rd burst read
    cyc(); drv(1, 0, 0, 0, 0, 1, 0, 32'h0C, 0, 1); ex(0,1,0,1,1,3,0,0,0); rq.push_back(32'h12345678);
    cyc(); drv(1, 1, 0, 32'h10, 0, 1, 0, 32'h0C, 0, 1); ex(1,1,0,1,1,3,1,0,0); rq.push_back(32'h12345678);
    cyc(); drv(0, 1, 0, 32'h10, 0, 1, 0, 32'h0C, 0, 1); ex(0,0,0,0,0,0,1,0,0);
    cyc(); drv(0, 1, 0, 32'h10, 0, 1, 0, 32'h0C, 0, 1); ex(0,0,0,0,0,0,0,0,0);
    cyc(); drv(1, 1, 0, 32'h10, 0, 1, 0, 32'h0C, 0, 1); ex(0,0,0,1,1,4,0,1,32'hDEADBEEF);
    cyc(); drv(1, 1, 0, 32'h10, 0, 1, 0, 32'h0C, 0, 1); ex(0,0,0,1,1,4,0,1,32'hDEADBEEF);
    cyc(); idle(); ex(0,0,0,0,0,0,0,0,0);

    @(negedge clk_in);
    #1;
    check("rdata_left", rq.size(), 0);
    check("exp_left", cq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
